// File: rtl/rename_map_table_if.sv
// Rename map table bus: one decode group in, renamed sources out, plus checkpoint control.
//   master : front end (drives the rename group, restore and release requests)
//   slave  : rename_map_table (returns the renamed IDs, acceptance and checkpoint state)
// Signals:
//   rn_valid/rn_rd/rn_rs1/rn_rs2/rn_new_prf : per-slot group fields, slot 0 is oldest
//   rn_ckpt_req                             : snapshot the table after this group
//   rn_ready                                : group accepted this cycle
//   rs1_prf/rs2_prf/old_rd_prf              : combinational lookup results per slot
//   ckpt_id/ckpt_full                       : checkpoint ID for this group, all checkpoints busy
//   restore_valid/restore_id                : mispredict restore request
//   release_valid                           : free the oldest checkpoint
interface rename_map_table_if #(
    parameter int unsigned AREG_W       = 5,
    parameter int unsigned PHYS_W       = 8,
    parameter int unsigned RENAME_WIDTH = 2,
    parameter int unsigned CKPT_W       = 2
);
    logic [RENAME_WIDTH-1:0]        rn_valid;
    logic [RENAME_WIDTH*AREG_W-1:0] rn_rd;
    logic [RENAME_WIDTH*AREG_W-1:0] rn_rs1;
    logic [RENAME_WIDTH*AREG_W-1:0] rn_rs2;
    logic [RENAME_WIDTH*PHYS_W-1:0] rn_new_prf;
    logic                           rn_ckpt_req;
    logic                           rn_ready;
    logic [RENAME_WIDTH*PHYS_W-1:0] rs1_prf;
    logic [RENAME_WIDTH*PHYS_W-1:0] rs2_prf;
    logic [RENAME_WIDTH*PHYS_W-1:0] old_rd_prf;
    logic [CKPT_W-1:0]              ckpt_id;
    logic                           ckpt_full;
    logic                           restore_valid;
    logic [CKPT_W-1:0]              restore_id;
    logic                           release_valid;

    modport master (
        output rn_valid, rn_rd, rn_rs1, rn_rs2, rn_new_prf, rn_ckpt_req,
        output restore_valid, restore_id, release_valid,
        input  rn_ready, rs1_prf, rs2_prf, old_rd_prf, ckpt_id, ckpt_full
    );

    modport slave (
        input  rn_valid, rn_rd, rn_rs1, rn_rs2, rn_new_prf, rn_ckpt_req,
        input  restore_valid, restore_id, release_valid,
        output rn_ready, rs1_prf, rs2_prf, old_rd_prf, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rename_map_table.sv
// Checkpointed register alias table. Renames up to RENAME_WIDTH instructions per cycle with
// intra-group bypass, snapshots the whole table for branch groups and restores it in one cycle.
// Ports:
//   CLK   : clock
//   Reset : synchronous, active-high reset (priority over everything)
//   bus   : rename_map_table_if slave (rename group, lookups, checkpoint control)
module rename_map_table #(
    parameter int unsigned ARCH_REGS    = 32,
    parameter int unsigned AREG_W       = 5,
    parameter int unsigned PHYS_W       = 8,
    parameter int unsigned RENAME_WIDTH = 2,
    parameter int unsigned NUM_CKPT     = 4,
    parameter int unsigned CKPT_W       = 2
) (
    input  logic                 CLK,
    input  logic                 Reset,
    rename_map_table_if.slave    bus
);

    // One extra bit so a completely full set of checkpoints is representable.
    localparam int unsigned CNT_W = CKPT_W + 1;

    logic [PHYS_W-1:0] r_table [ARCH_REGS];
    logic [PHYS_W-1:0] r_snap  [NUM_CKPT][ARCH_REGS];
    logic [CKPT_W-1:0] r_head;
    logic [CKPT_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_ckpt_full;

    logic [AREG_W-1:0] w_rd  [RENAME_WIDTH];
    logic [AREG_W-1:0] w_rs1 [RENAME_WIDTH];
    logic [AREG_W-1:0] w_rs2 [RENAME_WIDTH];
    logic [PHYS_W-1:0] w_new [RENAME_WIDTH];
    logic [PHYS_W-1:0] w_rs1_prf [RENAME_WIDTH];
    logic [PHYS_W-1:0] w_rs2_prf [RENAME_WIDTH];
    logic [PHYS_W-1:0] w_old_prf [RENAME_WIDTH];
    logic [PHYS_W-1:0] w_table_upd [ARCH_REGS];

    logic              w_ready;
    logic              w_fire;
    logic              w_alloc;
    logic              w_release;
    logic [CKPT_W-1:0] w_head_nxt;
    logic [CKPT_W-1:0] w_tail_nxt;
    logic [CKPT_W-1:0] w_diff;
    logic [CNT_W-1:0]  w_count_nxt;

    // A release in the same cycle frees a slot, so a full table may still allocate.
    assign w_ready   = !bus.restore_valid &&
                       !(bus.rn_ckpt_req && r_ckpt_full && !bus.release_valid);
    assign w_fire    = w_ready && (|bus.rn_valid);
    assign w_alloc   = w_fire && bus.rn_ckpt_req;
    assign w_release = bus.release_valid && (r_count != '0);

    assign bus.rn_ready  = w_ready;
    assign bus.ckpt_id   = r_tail;
    assign bus.ckpt_full = r_ckpt_full;

    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            w_rd[j]  = bus.rn_rd[j*AREG_W +: AREG_W];
            w_rs1[j] = bus.rn_rs1[j*AREG_W +: AREG_W];
            w_rs2[j] = bus.rn_rs2[j*AREG_W +: AREG_W];
            w_new[j] = bus.rn_new_prf[j*PHYS_W +: PHYS_W];
        end
    end

    // Lookup with bypass: scanning older slots in age order leaves the youngest match.
    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            w_rs1_prf[j] = r_table[w_rs1[j]];
            w_rs2_prf[j] = r_table[w_rs2[j]];
            w_old_prf[j] = r_table[w_rd[j]];
            for (int i = 0; i < j; i++) begin
                if (bus.rn_valid[i] && (w_rd[i] != '0)) begin
                    if (w_rd[i] == w_rs1[j]) w_rs1_prf[j] = w_new[i];
                    if (w_rd[i] == w_rs2[j]) w_rs2_prf[j] = w_new[i];
                    if (w_rd[i] == w_rd[j])  w_old_prf[j] = w_new[i];
                end
            end
        end
    end

    always_comb begin
        bus.rs1_prf    = '0;
        bus.rs2_prf    = '0;
        bus.old_rd_prf = '0;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            bus.rs1_prf[j*PHYS_W +: PHYS_W]    = w_rs1_prf[j];
            bus.rs2_prf[j*PHYS_W +: PHYS_W]    = w_rs2_prf[j];
            bus.old_rd_prf[j*PHYS_W +: PHYS_W] = w_old_prf[j];
        end
    end

    // Table as it stands after this group; later slots overwrite earlier ones.
    always_comb begin
        w_table_upd = r_table;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (bus.rn_valid[j] && (w_rd[j] != '0)) begin
                w_table_upd[w_rd[j]] = w_new[j];
            end
        end
    end

    // Checkpoint pointers. On restore the count is rebuilt from the (post-release) head;
    // a zero distance means the ring is full, except when the released head was the target.
    always_comb begin
        w_head_nxt  = r_head + CKPT_W'(w_release);
        w_tail_nxt  = r_tail;
        w_diff      = '0;
        w_count_nxt = r_count;
        if (bus.restore_valid) begin
            w_tail_nxt = bus.restore_id + CKPT_W'(1);
            w_diff     = bus.restore_id - w_head_nxt + CKPT_W'(1);
            if (w_release && (bus.restore_id == r_head)) begin
                w_count_nxt = '0;
            end else if (w_diff == '0) begin
                w_count_nxt = CNT_W'(NUM_CKPT);
            end else begin
                w_count_nxt = {1'b0, w_diff};
            end
        end else begin
            if (w_alloc) w_tail_nxt = r_tail + CKPT_W'(1);
            w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_release);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_table[i] <= PHYS_W'(i);
                for (int c = 0; c < NUM_CKPT; c++) begin
                    r_snap[c][i] <= PHYS_W'(i);
                end
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ckpt_full <= 1'b0;
        end else begin
            if (bus.restore_valid) begin
                r_table <= r_snap[bus.restore_id];
            end else if (w_fire) begin
                r_table <= w_table_upd;
            end
            if (w_alloc) begin
                r_snap[r_tail] <= w_table_upd;
            end
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_count     <= w_count_nxt;
            r_ckpt_full <= (w_count_nxt == CNT_W'(NUM_CKPT));
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;

    localparam int AW = 5;
    localparam int PW = 8;
    localparam int RW = 2;
    localparam int CW = 2;

    logic CLK = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    rename_map_table_if #(.AREG_W(AW), .PHYS_W(PW), .RENAME_WIDTH(RW), .CKPT_W(CW)) bus ();

    rename_map_table #(
        .ARCH_REGS(32), .AREG_W(AW), .PHYS_W(PW), .RENAME_WIDTH(RW), .NUM_CKPT(4), .CKPT_W(CW)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [RW*PW-1:0] v, input int s);
        return {24'd0, v[s*PW +: PW]};
    endfunction

    task automatic idle();
        bus.rn_valid      = '0;
        bus.rn_rd         = '0;
        bus.rn_rs1        = '0;
        bus.rn_rs2        = '0;
        bus.rn_new_prf    = '0;
        bus.rn_ckpt_req   = 1'b0;
        bus.restore_valid = 1'b0;
        bus.restore_id    = '0;
        bus.release_valid = 1'b0;
    endtask

    task automatic slot(input int s, input bit v, input int rd, input int rs1, input int rs2,
                        input int nw);
        bus.rn_valid[s]              = v;
        bus.rn_rd[s*AW +: AW]        = AW'(rd);
        bus.rn_rs1[s*AW +: AW]       = AW'(rs1);
        bus.rn_rs2[s*AW +: AW]       = AW'(rs2);
        bus.rn_new_prf[s*PW +: PW]   = PW'(nw);
    endtask

    // Start a new cycle with all inputs cleared; inputs change on the falling edge.
    task automatic next();
        @(negedge CLK);
        idle();
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        // Reset state
        slot(0, 0, 0, 13, 0, 0);
        slot(1, 0, 0, 0, 31, 0);
        #1;
        check("rst_rs1_13", fld(bus.rs1_prf, 0), 13);
        check("rst_rs2_31", fld(bus.rs2_prf, 1), 31);
        check("rst_ready", {31'd0, bus.rn_ready}, 1);
        check("rst_full", {31'd0, bus.ckpt_full}, 0);
        check("rst_id", {30'd0, bus.ckpt_id}, 0);

        // Intra-group bypass
        next();
        slot(0, 1, 5, 0, 0, 40);
        slot(1, 1, 6, 5, 6, 41);
        #1;
        check("t1_byp_rs1", fld(bus.rs1_prf, 1), 40);
        check("t1_own_rd", fld(bus.rs2_prf, 1), 6);
        check("t1_old0", fld(bus.old_rd_prf, 0), 5);
        check("t1_old1", fld(bus.old_rd_prf, 1), 6);
        next();
        slot(0, 0, 0, 5, 6, 0);
        #1;
        check("t1_tbl5", fld(bus.rs1_prf, 0), 40);
        check("t1_tbl6", fld(bus.rs2_prf, 0), 41);

        // Same rd in both slots: youngest wins
        next();
        slot(0, 1, 7, 0, 0, 50);
        slot(1, 1, 7, 0, 0, 51);
        #1;
        check("t2_old0", fld(bus.old_rd_prf, 0), 7);
        check("t2_old1", fld(bus.old_rd_prf, 1), 50);
        next();
        slot(0, 0, 0, 7, 0, 0);
        #1;
        check("t2_tbl7", fld(bus.rs1_prf, 0), 51);

        // x0 is never renamed or bypassed
        next();
        slot(0, 1, 0, 0, 0, 60);
        #1;
        check("t3_byp_x0", fld(bus.rs1_prf, 1), 0);
        check("t3_old_x0", fld(bus.old_rd_prf, 0), 0);
        next();
        #1;
        check("t3_tbl0", fld(bus.rs1_prf, 0), 0);

        // Invalid older slot does not bypass or write
        next();
        slot(0, 0, 5, 0, 0, 99);
        slot(1, 1, 10, 5, 0, 62);
        #1;
        check("t3_inv_byp", fld(bus.rs1_prf, 1), 40);
        next();
        slot(0, 0, 0, 5, 10, 0);
        #1;
        check("t3_inv_tbl5", fld(bus.rs1_prf, 0), 40);
        check("t3_tbl10", fld(bus.rs2_prf, 0), 62);

        // Checkpoint and restore
        next();
        slot(0, 1, 3, 0, 0, 70);
        bus.rn_ckpt_req = 1'b1;
        #1;
        check("t4_id0", {30'd0, bus.ckpt_id}, 0);
        check("t4_ready", {31'd0, bus.rn_ready}, 1);
        next();
        slot(0, 1, 3, 0, 0, 71);
        slot(1, 1, 4, 0, 0, 72);
        #1;
        check("t4_id1", {30'd0, bus.ckpt_id}, 1);
        check("t4_old3", fld(bus.old_rd_prf, 0), 70);
        next();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 2'd0;
        slot(0, 1, 11, 0, 0, 90);
        #1;
        check("t4_rst_ready", {31'd0, bus.rn_ready}, 0);
        next();
        slot(0, 0, 0, 3, 4, 0);
        slot(1, 0, 0, 11, 5, 0);
        #1;
        check("t4_r3", fld(bus.rs1_prf, 0), 70);
        check("t4_r4", fld(bus.rs2_prf, 0), 4);
        check("t4_r11_dropped", fld(bus.rs1_prf, 1), 11);
        check("t4_r5", fld(bus.rs2_prf, 1), 40);
        check("t4_tail", {30'd0, bus.ckpt_id}, 1);
        check("t4_full", {31'd0, bus.ckpt_full}, 0);

        // Count is 1 after restore: three more allocations fill the ring
        for (int k = 0; k < 3; k++) begin
            next();
            slot(0, 1, 12, 0, 0, 100 + k);
            bus.rn_ckpt_req = 1'b1;
            #1;
            check("t4_fill_id", {30'd0, bus.ckpt_id}, 32'(1 + k));
            check("t4_fill_nfull", {31'd0, bus.ckpt_full}, 0);
        end
        next();
        #1;
        check("t5_full", {31'd0, bus.ckpt_full}, 1);
        check("t5_tail_wrap", {30'd0, bus.ckpt_id}, 0);

        // Full: request stalls
        next();
        slot(0, 1, 13, 0, 0, 110);
        bus.rn_ckpt_req = 1'b1;
        #1;
        check("t5_stall", {31'd0, bus.rn_ready}, 0);
        next();
        slot(0, 0, 0, 13, 0, 0);
        #1;
        check("t5_nochg", fld(bus.rs1_prf, 0), 13);
        check("t5_still_full", {31'd0, bus.ckpt_full}, 1);

        // Full with release: accepted
        next();
        slot(0, 1, 13, 0, 0, 111);
        bus.rn_ckpt_req   = 1'b1;
        bus.release_valid = 1'b1;
        #1;
        check("t5_rel_ready", {31'd0, bus.rn_ready}, 1);
        check("t5_rel_id", {30'd0, bus.ckpt_id}, 0);
        next();
        slot(0, 0, 0, 13, 0, 0);
        #1;
        check("t5_tbl13", fld(bus.rs1_prf, 0), 111);
        check("t5_full_kept", {31'd0, bus.ckpt_full}, 1);
        check("t5_tail1", {30'd0, bus.ckpt_id}, 1);

        // Restore drops a concurrent group
        next();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 2'd2;
        slot(0, 1, 9, 0, 0, 80);
        #1;
        check("t6_ready", {31'd0, bus.rn_ready}, 0);
        next();
        slot(0, 0, 0, 9, 12, 0);
        slot(1, 0, 0, 13, 0, 0);
        #1;
        check("t6_r9", fld(bus.rs1_prf, 0), 9);
        check("t6_r12", fld(bus.rs2_prf, 0), 101);
        check("t6_r13", fld(bus.rs1_prf, 1), 13);
        check("t6_tail", {30'd0, bus.ckpt_id}, 3);
        check("t6_nfull", {31'd0, bus.ckpt_full}, 0);

        // Restore of the head while it is released: count becomes 0, not full
        next();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 2'd1;
        bus.release_valid = 1'b1;
        #1;
        check("t6_rr_ready", {31'd0, bus.rn_ready}, 0);
        next();
        slot(0, 0, 0, 12, 0, 0);
        #1;
        check("t6_rr_r12", fld(bus.rs1_prf, 0), 100);
        check("t6_rr_tail", {30'd0, bus.ckpt_id}, 2);
        check("t6_rr_nfull", {31'd0, bus.ckpt_full}, 0);

        // Reset mid-sequence
        next();
        slot(0, 1, 14, 0, 0, 120);
        bus.rn_ckpt_req = 1'b1;
        next();
        Reset = 1'b1;
        slot(0, 1, 15, 0, 0, 121);
        next();
        Reset = 1'b0;
        slot(0, 0, 0, 14, 15, 0);
        #1;
        check("t6_rst_r14", fld(bus.rs1_prf, 0), 14);
        check("t6_rst_r15", fld(bus.rs2_prf, 0), 15);
        check("t6_rst_id", {30'd0, bus.ckpt_id}, 0);
        check("t6_rst_full", {31'd0, bus.ckpt_full}, 0);
        check("t6_rst_ready", {31'd0, bus.rn_ready}, 1);
        for (int k = 0; k < 4; k++) begin
            next();
            slot(0, 1, 16, 0, 0, 130 + k);
            bus.rn_ckpt_req = 1'b1;
            #1;
            check("t6_cnt_id", {30'd0, bus.ckpt_id}, 32'(k));
            check("t6_cnt_nfull", {31'd0, bus.ckpt_full}, 0);
        end
        next();
        #1;
        check("t6_cnt_full", {31'd0, bus.ckpt_full}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
